// File: rtl/ice40_serdes_crg_seq.sv
// Clock/reset sequencer: power-of-two divided clocks from one counter, a hold/settle
// power-up sequence, runtime re-reset requests, a slow-period strobe and a ready flag.
module ice40_serdes_crg_seq #(
    parameter int unsigned DIV_W    = 2,
    parameter int unsigned RST_HOLD = 15,
    parameter int unsigned SETTLE   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_req,
    output logic [DIV_W-1:0] clk_out,
    output logic             rst_out,
    output logic             stb_out,
    output logic             ready
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam int unsigned SET_W  = $clog2(SETTLE + 1);

    localparam logic [DIV_W-1:0]  CNT_MAX   = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  cnt_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nx;
    logic [SET_W-1:0]  settle_cnt;
    logic [SET_W-1:0]  settle_nx;
    logic              rst_out_nx;
    logic              stb_nx;
    logic              ready_nx;
    logic              wrap;

    // Every divided clock is a bit of the shared counter flop, so no glitches or skewed ripple.
    assign clk_out = cnt;
    assign wrap    = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HOLD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        hold_nx    = hold_cnt;
        settle_nx  = settle_cnt;
        rst_out_nx = rst_out;
        stb_nx     = 1'b0;

        case (state)
            ST_HOLD: begin
                cnt_nx     = '0;
                rst_out_nx = 1'b1;
                hold_nx    = hold_cnt + HOLD_W'(1);
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_nx     = cnt + DIV_W'(1);
                stb_nx     = wrap;
                rst_out_nx = 1'b1;
                // A restart request wins over a coincident final wrap.
                if (rst_req) begin
                    settle_nx = '0;
                end else if (wrap) begin
                    if (settle_cnt == SET_LAST) begin
                        state_nx   = ST_RUN;
                        settle_nx  = '0;
                        rst_out_nx = 1'b0;
                    end else begin
                        settle_nx = settle_cnt + SET_W'(1);
                    end
                end
            end
            ST_RUN: begin
                cnt_nx     = cnt + DIV_W'(1);
                stb_nx     = wrap;
                rst_out_nx = 1'b0;
                // Counter keeps running so downstream clock phase is continuous.
                if (rst_req) begin
                    state_nx   = ST_SETTLE;
                    settle_nx  = '0;
                    rst_out_nx = 1'b1;
                end
            end
            default: begin
                state_nx   = ST_HOLD;
                cnt_nx     = '0;
                hold_nx    = '0;
                settle_nx  = '0;
                rst_out_nx = 1'b1;
            end
        endcase

        ready_nx = (state_nx == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            hold_cnt   <= '0;
            settle_cnt <= '0;
            rst_out    <= 1'b1;
            stb_out    <= 1'b0;
            ready      <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            hold_cnt   <= hold_nx;
            settle_cnt <= settle_nx;
            rst_out    <= rst_out_nx;
            stb_out    <= stb_nx;
            ready      <= ready_nx;
        end
    end

endmodule

// File: tb/tb_ice40_serdes_crg_seq.sv
// Bench for ice40_serdes_crg_seq: three parameterisations driven from one clock and
// checked against an edge-counting reference model plus fixed timing expectations.
module tb_ice40_serdes_crg_seq;

    localparam int NI = 3;
    localparam int DW [NI] = '{2, 3, 2};
    localparam int HD [NI] = '{15, 4, 15};
    localparam int ST [NI] = '{1, 3, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_v;
    logic [NI-1:0] req_v;
    logic [1:0]    co_a;
    logic [2:0]    co_b;
    logic [1:0]    co_c;
    logic [NI-1:0] ro;
    logic [NI-1:0] so;
    logic [NI-1:0] rdy;

    ice40_serdes_crg_seq #(.DIV_W(2), .RST_HOLD(15), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst_v[0]), .rst_req(req_v[0]),
        .clk_out(co_a), .rst_out(ro[0]), .stb_out(so[0]), .ready(rdy[0]));
    ice40_serdes_crg_seq #(.DIV_W(3), .RST_HOLD(4), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst_v[1]), .rst_req(req_v[1]),
        .clk_out(co_b), .rst_out(ro[1]), .stb_out(so[1]), .ready(rdy[1]));
    ice40_serdes_crg_seq #(.DIV_W(2), .RST_HOLD(15), .SETTLE(2)) u_c (
        .clk(clk), .rst(rst_v[2]), .rst_req(req_v[2]),
        .clk_out(co_c), .rst_out(ro[2]), .stb_out(so[2]), .ready(rdy[2]));

    int a_clk [NI];
    always_comb begin
        a_clk[0] = int'(co_a);
        a_clk[1] = int'(co_b);
        a_clk[2] = int'(co_c);
    end

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: edges since reset, running phase, wraps still owed before release.
    int m_edge [NI] = '{0, 0, 0};
    int m_cnt  [NI] = '{0, 0, 0};
    int m_left [NI] = '{0, 0, 0};
    bit m_run  [NI] = '{0, 0, 0};
    bit m_rel  [NI] = '{0, 0, 0};
    bit m_stb  [NI] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int  p;
            int  e;
            bit  w;
            p = 1 << DW[i];
            e = m_edge[i] + 1;
            w = (m_cnt[i] == p - 1);
            if (rst_v[i]) begin
                m_edge[i] <= 0;
                m_cnt[i]  <= 0;
                m_run[i]  <= 1'b0;
                m_rel[i]  <= 1'b0;
                m_stb[i]  <= 1'b0;
                m_left[i] <= ST[i];
            end else if (!m_run[i]) begin
                m_edge[i] <= e;
                m_stb[i]  <= 1'b0;
                if (e == HD[i]) m_run[i] <= 1'b1;
            end else begin
                m_edge[i] <= e;
                m_cnt[i]  <= (m_cnt[i] + 1) % p;
                m_stb[i]  <= w;
                if (req_v[i]) begin
                    m_left[i] <= ST[i];
                    m_rel[i]  <= 1'b0;
                end else if (w && !m_rel[i]) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) m_rel[i] <= 1'b1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_v = '1;
        req_v = '0;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            n_run++;
            if (a_clk[i] !== 0 || ro[i] !== 1'b1 || so[i] !== 1'b0 || rdy[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset inst%0d: clk=%0d rst_out=%b stb=%b ready=%b want 0/1/0/0",
                         i, a_clk[i], ro[i], so[i], rdy[i]);
            end
        end
    endtask

    task automatic test_powerup;
        int rise [NI] = '{0, 0, 0};
        int exp_rise [NI] = '{19, 28, 23};
        int stb_n = 0;
        int stb_sum = 0;
        rst_v = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                n_run++;
                if (a_clk[i] !== m_cnt[i] || ro[i] !== !m_rel[i] || so[i] !== m_stb[i] ||
                    rdy[i] !== m_rel[i]) begin
                    n_fail++;
                    $display("FAIL powerup inst%0d edge%0d: clk=%0d ro=%b stb=%b rdy=%b want %0d/%b/%b/%b",
                             i, k, a_clk[i], ro[i], so[i], rdy[i], m_cnt[i], !m_rel[i], m_stb[i], m_rel[i]);
                end
                if (rdy[i] && rise[i] == 0) rise[i] = k;
            end
            if (so[1] && k <= 28) begin
                stb_n++;
                stb_sum += k;
            end
            if (k == 15 || k == 16) begin
                n_run++;
                if (a_clk[0] !== k - 15) begin
                    n_fail++;
                    $display("FAIL hold_end edge%0d: clk=%0d want %0d", k, a_clk[0], k - 15);
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            n_run++;
            if (rise[i] != exp_rise[i]) begin
                n_fail++;
                $display("FAIL release_edge inst%0d: got %0d want %0d", i, rise[i], exp_rise[i]);
            end
        end
        n_run++;
        if (stb_n != 3 || stb_sum != 12 + 20 + 28) begin
            n_fail++;
            $display("FAIL settle_strobes: count=%0d edgesum=%0d want 3/60", stb_n, stb_sum);
        end
    endtask

    // Edges from a given post-edge count value until the second counted wrap (DIV_W=2).
    function automatic int second_wrap(input int c1);
        return ((c1 == 0) ? 4 : 4 - c1) + 4;
    endfunction

    task automatic test_req_run;
        int c0;
        int fall = 0;
        int want;
        c0 = a_clk[2];
        req_v[2] = 1'b1;
        tick();
        req_v[2] = 1'b0;
        n_run++;
        if (ro[2] !== 1'b1 || rdy[2] !== 1'b0 || a_clk[2] !== (c0 + 1) % 4) begin
            n_fail++;
            $display("FAIL req_run_assert: ro=%b rdy=%b clk=%0d want 1/0/%0d",
                     ro[2], rdy[2], a_clk[2], (c0 + 1) % 4);
        end
        want = second_wrap(a_clk[2]);
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_run++;
            if (ro[2] !== !m_rel[2] || a_clk[2] !== m_cnt[2] || so[2] !== m_stb[2]) begin
                n_fail++;
                $display("FAIL req_run_model edge%0d: ro=%b clk=%0d stb=%b want %b/%0d/%b",
                         k, ro[2], a_clk[2], so[2], !m_rel[2], m_cnt[2], m_stb[2]);
            end
            if (!ro[2] && fall == 0) fall = k;
        end
        n_run++;
        if (fall != want) begin
            n_fail++;
            $display("FAIL req_run_release: edge %0d want %0d", fall, want);
        end
    endtask

    task automatic test_req_hold;
        int fall = 0;
        int want;
        req_v[2] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            n_run++;
            if (ro[2] !== 1'b1 || rdy[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL req_hold edge%0d: ro=%b rdy=%b want 1/0", k, ro[2], rdy[2]);
            end
        end
        req_v[2] = 1'b0;
        want = second_wrap((a_clk[2] + 1) % 4) + 1;
        for (int k = 1; k <= 20 && fall == 0; k++) begin
            tick();
            if (!ro[2]) fall = k;
        end
        n_run++;
        if (fall != want || fall < 5 || fall > 8 || a_clk[2] !== 0) begin
            n_fail++;
            $display("FAIL req_hold_release: edge %0d clk=%0d want edge %0d clk 0", fall, a_clk[2], want);
        end
    endtask

    task automatic test_rst_mid;
        bit found = 1'b0;
        int rise = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (rdy[0] && a_clk[0] == 2) found = 1'b1;
            else tick();
        end
        n_run++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_wait: ready=%b clk=%0d want 1/2", rdy[0], a_clk[0]);
        end
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        n_run++;
        if (a_clk[0] !== 0 || ro[0] !== 1'b1 || rdy[0] !== 1'b0 || so[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: clk=%0d ro=%b rdy=%b stb=%b want 0/1/0/0", a_clk[0], ro[0], rdy[0], so[0]);
        end
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (rdy[0] && rise == 0) rise = k;
            if (k == 15) begin
                n_run++;
                if (a_clk[0] !== 0) begin
                    n_fail++;
                    $display("FAIL rst_mid_hold: clk=%0d want 0", a_clk[0]);
                end
            end
        end
        n_run++;
        if (rise != 19) begin
            n_fail++;
            $display("FAIL rst_mid_release: edge %0d want 19", rise);
        end
    endtask

    task automatic test_req_wrap;
        bit found = 1'b0;
        int fall = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (rdy[0] && a_clk[0] == 3) found = 1'b1;
            else tick();
        end
        req_v[0] = 1'b1;
        tick();
        req_v[0] = 1'b0;
        n_run++;
        if (!found || ro[0] !== 1'b1 || a_clk[0] !== 0 || so[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL req_wrap_assert: found=%b ro=%b clk=%0d stb=%b want 1/1/0/1",
                     found, ro[0], a_clk[0], so[0]);
        end
        for (int k = 1; k <= 12 && fall == 0; k++) begin
            tick();
            if (!ro[0]) fall = k;
        end
        n_run++;
        if (fall != 4) begin
            n_fail++;
            $display("FAIL req_wrap_release: edge %0d want 4", fall);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NI; i++) begin
                req_v[i] = ($urandom_range(0, 7) == 0);
                rst_v[i] = ($urandom_range(0, 149) == 0);
            end
            tick();
            for (int i = 0; i < NI; i++) begin
                n_run++;
                if (a_clk[i] !== m_cnt[i] || ro[i] !== !m_rel[i] || so[i] !== m_stb[i] ||
                    rdy[i] !== m_rel[i]) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d: clk=%0d ro=%b stb=%b rdy=%b want %0d/%b/%b/%b",
                             i, k, a_clk[i], ro[i], so[i], rdy[i], m_cnt[i], !m_rel[i], m_stb[i], m_rel[i]);
                end
            end
        end
        rst_v = '0;
        req_v = '0;
    endtask

    initial begin
        rst_v = '1;
        req_v = '0;
        test_reset();
        test_powerup();
        test_req_run();
        test_req_hold();
        test_rst_mid();
        test_req_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ice40_serdes_crg_seq.md
# ice40_serdes_crg_seq

Parametrised clock/reset sequencer for SERDES-style multi-rate datapaths. It is clocked by the fastest PLL-derived clock and generates DIV_W ripple-free power-of-two divided clocks from a single counter. It holds the divider stopped for a programmable time after reset, then runs it for a programmable number of slowest-clock periods before releasing a phase-aligned reset. Unlike the fixed 4x/2x/1x generator, it supports runtime re-reset requests without stopping the clocks, plus a phase strobe and a ready flag. Global-buffer insertion on the outputs is done by the instantiating wrapper.

## Interface
- DIV_W, default 2: number of divided clock outputs, 1..4; clk_out[k] = clk / 2^(k+1).
- RST_HOLD, default 15: cycles the divider is held stopped after rst, ≥1.
- SETTLE, default 1: slowest-clock periods the divider runs with rst_out asserted, ≥1.

- clk  in  1  fastest clock (PLL output); sole clock of the block.
- rst  in  1  synchronous, active-high reset (PLL not locked, synchronised upstream).
- rst_req  in  1  request re-reset of downstream logic while clocks keep running; level, sampled each cycle.
- clk_out  out  DIV_W  divided clocks, clk_out[k] = cnt[k] (registered, glitch-free).
- rst_out  out  1  downstream reset, active-high, deasserts phase-aligned to slowest clock.
- stb_out  out  1  one-cycle pulse in the clk cycle where cnt == 0 (start of slowest period); only while the divider runs.
- ready  out  1  high iff state is RUN.

## Operation
- Registers: cnt[DIV_W-1:0], hold_cnt ($clog2(RST_HOLD+1) bits), settle_cnt ($clog2(SETTLE+1) bits), and a 2-bit state register with states HOLD, SETTLE and RUN.
- rst has priority over everything. On rst: state=HOLD, cnt=0, hold_cnt=0, settle_cnt=0, clk_out=0, rst_out=1, stb_out=0, ready=0.
- HOLD: cnt frozen at 0, so every clk_out is low.
  - hold_cnt increments each cycle.
  - When hold_cnt == RST_HOLD-1, the next state is SETTLE.
  - rst_req is ignored.
- SETTLE: cnt increments by 1 each cycle, modulo 2^DIV_W.
  - A wrap is a cycle where cnt == all-ones, so cnt becomes 0 on the next edge.
  - settle_cnt increments on each wrap.
  - The wrap with settle_cnt == SETTLE-1 moves the state to RUN and deasserts rst_out on that same edge.
  - rst_req high in SETTLE clears settle_cnt and stays in SETTLE (the restart takes priority over a coincident final wrap).
- RUN: cnt keeps incrementing and rst_out=0.
  - rst_req high on an edge moves the state to SETTLE with settle_cnt=0, and rst_out=1 from that edge.
  - cnt is not disturbed, so clock phase is continuous.
  - A wrap on the same edge as rst_req is not counted.
- stb_out is registered: it is 1 in the cycle after a wrap edge, i.e. while cnt==0, in SETTLE and RUN only. In HOLD it stays 0 even though cnt==0.
- rst_out deasserts only on an edge where cnt becomes 0. That point is the start of the slowest clock's low phase, giving downstream a half slow period of setup before its next rising edge.

## Timing
- Edge numbering: edge 1 is the first clk rising edge with rst low.
- HOLD occupies edges 1..RST_HOLD. cnt becomes 1 at edge RST_HOLD+1.
- First wrap edge = RST_HOLD + 2^DIV_W. rst_out falls and ready rises at edge RST_HOLD + SETTLE·2^DIV_W.
- Latencies:
  - rst_req to rst_out=1: one edge.
  - rst_req deassertion to rst_out=0: at the SETTLE-th subsequent wrap, i.e. between (SETTLE-1)·2^DIV_W+1 and SETTLE·2^DIV_W edges.
- rst asserted mid-operation: all outputs take their reset values on the next edge; clk_out drops low immediately (truncated period permitted).
- All outputs are direct flop outputs; no combinational paths from inputs to outputs.

## Test plan
- Power-up with DIV_W=2, RST_HOLD=15, SETTLE=1:
  - clk_out=0 through edge 15 and cnt=1 at edge 16.
  - rst_out falls and ready rises at edge 19; stb_out=1 after edges 19, 23, 27…
  - clk_out[1] has period 4 and clk_out[0] has period 2.
- DIV_W=3, RST_HOLD=4, SETTLE=3: rst_out falls at edge 4+24=28 with cnt=0. Check that stb_out pulses three times before that, after edges 12 and 20 and coinciding with the release at 28.
- rst_req for one cycle in RUN with DIV_W=2, SETTLE=2:
  - rst_out=1 next edge and ready=0.
  - clk_out continues without phase jump.
  - rst_out falls at the second wrap after the request.
- rst_req held high across three wraps in SETTLE: rst_out stays 1. After release, rst_out falls at the SETTLE-th wrap following deassertion.
- rst asserted mid-RUN with cnt=2: all clk_out=0, rst_out=1 and ready=0 after that edge, then the full power-up sequence repeats.
- rst_req coincident with a wrap edge in RUN (SETTLE=1): that wrap is not counted, and rst_out falls at the next wrap, 2^DIV_W edges later.
